// File: rtl/micro_bus_pkg.sv
// Shared types and constants for the micro bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package micro_bus_pkg;

    // Arbiter ownership states: nobody owns the slave port, or one master does.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Read data returned to a master whose transaction was aborted by the watchdog.
    // Sized for the widest data bus; users slice it down to their own width.
    localparam int                    MAX_WIDTHD = 64;
    localparam logic [MAX_WIDTHD-1:0] ALL_ONES   = '1;

endpackage

// File: rtl/micro_bus_arbiter_rr_priority.sv
// Round-robin select: the first requester after the previous owner wins.
// Latency: purely combinational.
// Backpressure: none; the result is a function of the current requests only.
module rr_priority
    import micro_bus_pkg::*;
#(
    parameter int N    = 2,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] last,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            any_req
);

    logic [N-1:0]    rot;
    logic [IDXW-1:0] first;
    logic            found;

    // Rotate so the master after 'last' sits at bit 0, find the first set bit, then map back.
    always_comb begin
        rot   = '0;
        first = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            rot[k] = req[IDXW'((int'(last) + 1 + k) % N)];
        end
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                first = IDXW'(k);
            end
        end
        grant_idx = IDXW'((int'(last) + 1 + int'(first)) % N);
        grant     = '0;
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
        any_req = found;
    end

endmodule

// File: rtl/micro_bus_arbiter.sv
// Round-robin arbiter sharing one registered slave port between NUM_MASTERS cores, with a watchdog.
// Latency: request to slave strobe 1 cycle; completion no earlier than that cycle; one idle cycle between grants.
// Backpressure: slave waitrequest holds the owner's m_waitrequest high until ready or watchdog abort.
module micro_bus_arbiter
    import micro_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int WIDTHA      = 16,
    parameter int WIDTHD      = 18,
    parameter int TIMEOUT     = 255,
    parameter int WIDTHT      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                          clock,
    input  logic                          clock_sreset,
    input  logic [NUM_MASTERS*WIDTHA-1:0] m_address,
    input  logic [NUM_MASTERS*WIDTHD-1:0] m_writedata,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    output logic [WIDTHD-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [WIDTHA-1:0]             s_address,
    output logic [WIDTHD-1:0]             s_writedata,
    output logic                          s_read,
    output logic                          s_write,
    input  logic [WIDTHD-1:0]             s_readdata,
    input  logic                          s_waitrequest,
    output logic                          timeout,
    output logic [NUM_MASTERS-1:0]        grant
);

    localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    // Count value in the last waiting cycle the watchdog tolerates.
    localparam logic [WIDTHT-1:0] CNT_LAST = WIDTHT'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                   state;
    state_t                   state_nxt;
    logic [NUM_MASTERS-1:0]   req;
    logic [NUM_MASTERS-1:0]   win_oh;
    logic [IDXW-1:0]          win_idx;
    logic                     win_any;
    logic [IDXW-1:0]          last;
    logic [IDXW-1:0]          owner;
    logic [WIDTHT-1:0]        count;
    logic                     abort;
    logic                     done;
    logic [WIDTHA-1:0]        win_addr;
    logic [WIDTHD-1:0]        win_wdata;
    logic                     win_rd;
    logic                     win_wr;

    assign req = m_read | m_write;

    rr_priority #(
        .N    (NUM_MASTERS),
        .IDXW (IDXW)
    ) u_rr (
        .req       (req),
        .last      (last),
        .grant     (win_oh),
        .grant_idx (win_idx),
        .any_req   (win_any)
    );

    // Select the winning master's address, data and strobes for latching at grant.
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_oh[i]) begin
                win_addr  = m_address[i*WIDTHA +: WIDTHA];
                win_wdata = m_writedata[i*WIDTHD +: WIDTHD];
            end
        end
        win_rd = |(m_read & win_oh);
        win_wr = |(m_write & win_oh);
    end

    // Completion is either the slave dropping waitrequest or the watchdog giving up on it.
    always_comb begin
        abort = 1'b0;
        if (TIMEOUT != 0) begin
            abort = (state == BUSY) && s_waitrequest && (count == CNT_LAST);
        end
        done = (state == BUSY) && (!s_waitrequest || abort);
    end

    assign timeout       = abort;
    assign m_waitrequest = ~(grant & {NUM_MASTERS{done}});
    assign m_readdata    = abort ? ALL_ONES[WIDTHD-1:0] : s_readdata;

    // State register.
    always_ff @(posedge clock or posedge clock_sreset) begin
        if (clock_sreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: grab the port on any request, release it on completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_any) state_nxt = BUSY;
            BUSY:    if (done)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slave-side registers, ownership tracking and watchdog counter.
    always_ff @(posedge clock or posedge clock_sreset) begin
        if (clock_sreset) begin
            s_address   <= '0;
            s_writedata <= '0;
            s_read      <= 1'b0;
            s_write     <= 1'b0;
            grant       <= '0;
            owner       <= '0;
            last        <= IDXW'(NUM_MASTERS - 1);
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        s_address   <= win_addr;
                        s_writedata <= win_wdata;
                        s_read      <= win_rd;
                        s_write     <= win_wr;
                        grant       <= win_oh;
                        owner       <= win_idx;
                        count       <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        s_address   <= '0;
                        s_writedata <= '0;
                        s_read      <= 1'b0;
                        s_write     <= 1'b0;
                        grant       <= '0;
                        last        <= owner;
                    end else if (s_waitrequest) begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_micro_bus_arbiter.sv
// Self-checking bench for micro_bus_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (owner, age in BUSY, latched request).
module tb_micro_bus_arbiter;

    localparam int N  = 2;
    localparam int WA = 16;
    localparam int WD = 18;
    localparam int TO = 4;

    logic            clock = 1'b0;
    logic            clock_sreset = 1'b1;
    logic [N*WA-1:0] m_address;
    logic [N*WD-1:0] m_writedata;
    logic [N-1:0]    m_read;
    logic [N-1:0]    m_write;
    logic [WD-1:0]   m_readdata;
    logic [N-1:0]    m_waitrequest;
    logic [WA-1:0]   s_address;
    logic [WD-1:0]   s_writedata;
    logic            s_read;
    logic            s_write;
    logic [WD-1:0]   s_readdata = '0;
    logic            s_waitrequest = 1'b0;
    logic            timeout;
    logic [N-1:0]    grant;

    // Per-master stimulus, packed onto the DUT buses below.
    logic [WA-1:0] addr_a [N];
    logic [WD-1:0] wd_a   [N];
    logic          rd_a   [N];
    logic          wr_a   [N];

    always_comb begin
        m_address   = '0;
        m_writedata = '0;
        m_read      = '0;
        m_write     = '0;
        for (int i = 0; i < N; i++) begin
            m_address[i*WA +: WA]   = addr_a[i];
            m_writedata[i*WD +: WD] = wd_a[i];
            m_read[i]               = rd_a[i];
            m_write[i]              = wr_a[i];
        end
    end

    micro_bus_arbiter #(
        .NUM_MASTERS (N),
        .WIDTHA      (WA),
        .WIDTHD      (WD),
        .TIMEOUT     (TO)
    ) dut (
        .clock         (clock),
        .clock_sreset  (clock_sreset),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .s_address     (s_address),
        .s_writedata   (s_writedata),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .timeout       (timeout),
        .grant         (grant)
    );

    always #5 clock = ~clock;

    // A master may never issue read and write together.
    always @(negedge clock) begin
        if (!clock_sreset) begin
            assert (!(|(m_read & m_write)))
                else $error("FAIL rw_both read=%b write=%b", m_read, m_write);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port, how many cycles it has been BUSY, what was latched.
    logic          mb_busy;
    int            mb_owner;
    int            mb_last;
    int            mb_age;
    logic [WA-1:0] mb_addr;
    logic [WD-1:0] mb_wdata;
    logic          mb_rd;
    logic          mb_wr;
    logic          cyc_done;
    int            cyc_owner;
    logic [N-1:0]  prev_grant;
    logic [N-1:0]  obs[$];

    task automatic model_reset();
        mb_busy  = 1'b0;
        mb_owner = 0;
        mb_last  = N - 1;
        mb_age   = 0;
        mb_addr  = '0;
        mb_wdata = '0;
        mb_rd    = 1'b0;
        mb_wr    = 1'b0;
        cyc_done = 1'b0;
    endtask

    task automatic check_outputs();
        logic         ab;
        logic         dn;
        logic [N-1:0] ew;
        logic [N-1:0] eg;
        ab = mb_busy && s_waitrequest && (mb_age == TO);
        dn = mb_busy && (!s_waitrequest || ab);
        ew = dn ? ~(N'(1) << mb_owner) : '1;
        eg = mb_busy ? (N'(1) << mb_owner) : '0;
        chk("s_read",        64'(s_read),        64'(mb_busy & mb_rd));
        chk("s_write",       64'(s_write),       64'(mb_busy & mb_wr));
        chk("s_address",     64'(s_address),     64'(mb_busy ? mb_addr : '0));
        chk("s_writedata",   64'(s_writedata),   64'(mb_busy ? mb_wdata : '0));
        chk("grant",         64'(grant),         64'(eg));
        chk("m_waitrequest", 64'(m_waitrequest), 64'(ew));
        chk("timeout",       64'(timeout),       64'(ab));
        chk("m_readdata",    64'(m_readdata),    64'(ab ? {WD{1'b1}} : s_readdata));
        cyc_done  = dn;
        cyc_owner = mb_owner;
        if (grant != '0 && prev_grant == '0) obs.push_back(grant);
        prev_grant = grant;
    endtask

    task automatic update_model();
        if (mb_busy) begin
            if (cyc_done) begin
                mb_busy = 1'b0;
                mb_last = mb_owner;
            end else begin
                mb_age++;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mb_last + k) % N;
                if (rd_a[c] || wr_a[c]) begin
                    mb_busy  = 1'b1;
                    mb_owner = c;
                    mb_age   = 1;
                    mb_addr  = addr_a[c];
                    mb_wdata = wd_a[c];
                    mb_rd    = rd_a[c];
                    mb_wr    = wr_a[c];
                    break;
                end
            end
        end
    endtask

    // One clock: check outputs mid-cycle, advance model at the edge, return just after it.
    task automatic step();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        update_model();
        #1;
    endtask

    task automatic clear_masters();
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0;
            wd_a[i]   = '0;
            rd_a[i]   = 1'b0;
            wr_a[i]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        clock_sreset  = 1'b1;
        clear_masters();
        s_waitrequest = 1'b0;
        s_readdata    = '0;
        model_reset();
        prev_grant    = '0;
        repeat (2) @(posedge clock);
        #1;
        clock_sreset = 1'b0;
    endtask

    logic pend [N];

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_s_read", 64'(s_read), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_mwait", 64'(m_waitrequest), 64'(2'b11));
        step();

        // Single read, slave ready
        do_reset();
        rd_a[0] = 1'b1;
        addr_a[0] = 16'h0024;
        step();
        #1;
        chk("t1_s_read", 64'(s_read), 64'(1));
        chk("t1_s_address", 64'(s_address), 64'(16'h0024));
        chk("t1_mwait", 64'(m_waitrequest), 64'(2'b10));
        step();
        rd_a[0] = 1'b0;
        #1;
        chk("t1_s_read_drop", 64'(s_read), 64'(0));
        step();

        // Both masters reading continuously: grants rotate
        do_reset();
        rd_a[0] = 1'b1; addr_a[0] = 16'h0100;
        rd_a[1] = 1'b1; addr_a[1] = 16'h0200;
        obs.delete();
        repeat (12) step();
        chk("t2_count", 64'(obs.size() >= 5), 64'(1));
        for (int i = 0; i < obs.size(); i++) begin
            chk("t2_rot", 64'(obs[i]), 64'(N'(1) << (i % N)));
        end
        clear_masters();
        step();

        // Write with three wait cycles
        do_reset();
        wr_a[1] = 1'b1; addr_a[1] = 16'h01E0; wd_a[1] = 18'h155AA;
        s_waitrequest = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            s_waitrequest = (c < 3);
            #1;
            chk("t3_s_write", 64'(s_write), 64'(1));
            chk("t3_addr", 64'(s_address), 64'(16'h01E0));
            chk("t3_data", 64'(s_writedata), 64'(18'h155AA));
            chk("t3_mwait", 64'(m_waitrequest), 64'((c < 3) ? 2'b11 : 2'b01));
            step();
        end
        wr_a[1] = 1'b0;
        step();

        // Watchdog abort on a stuck read
        do_reset();
        rd_a[0] = 1'b1; addr_a[0] = 16'h0042;
        s_waitrequest = 1'b1;
        s_readdata = 18'h12345;
        step();
        for (int c = 1; c <= TO; c++) begin
            #1;
            chk("t4_timeout", 64'(timeout), 64'(c == TO));
            if (c == TO) begin
                chk("t4_mwait", 64'(m_waitrequest), 64'(2'b10));
                chk("t4_rdata", 64'(m_readdata), 64'(18'h3FFFF));
            end
            step();
        end
        rd_a[0] = 1'b0;
        s_waitrequest = 1'b0;
        #1;
        chk("t4_idle_grant", 64'(grant), 64'(0));
        step();

        // Asynchronous reset while BUSY
        do_reset();
        rd_a[0] = 1'b1; rd_a[1] = 1'b1;
        s_waitrequest = 1'b1;
        step();
        step();
        #2;
        clock_sreset = 1'b1;
        #1;
        chk("t5_s_read", 64'(s_read), 64'(0));
        chk("t5_s_write", 64'(s_write), 64'(0));
        chk("t5_grant", 64'(grant), 64'(0));
        model_reset();
        prev_grant = '0;
        s_waitrequest = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        clock_sreset = 1'b0;
        step();
        #1;
        chk("t5_first_win", 64'(grant), 64'(2'b01));
        step();
        clear_masters();
        step();
        step();

        // Address change while BUSY is ignored
        do_reset();
        rd_a[0] = 1'b1; addr_a[0] = 16'h1111;
        s_waitrequest = 1'b1;
        step();
        addr_a[0] = 16'h2222;
        #1;
        chk("t6_addr_hold", 64'(s_address), 64'(16'h1111));
        step();
        s_waitrequest = 1'b0;
        step();
        rd_a[0] = 1'b0;
        step();

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && cyc_done && cyc_owner == i) begin
                    pend[i] = 1'b0;
                    rd_a[i] = 1'b0;
                    wr_a[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]   = 1'b1;
                    rd_a[i]   = ($urandom_range(0, 1) == 1);
                    wr_a[i]   = !rd_a[i];
                    addr_a[i] = WA'($urandom);
                    wd_a[i]   = WD'($urandom);
                end
            end
            s_waitrequest = ($urandom_range(0, 9) < 6);
            s_readdata    = WD'($urandom);
            cyc_done      = 1'b0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog sim_time got=%0t want<200000", $time);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/micro_bus_arbiter.md
Name: micro_bus_arbiter

Overview:
Round-robin arbiter that shares one registered memory/IO slave port between NUM_MASTERS micro cores (or a micro plus a DMA engine).
- Each master side is a read/write/waitrequest bus with single-word transfers and one outstanding transaction.
- Sits between the micro instances and the shared block RAM / IO fabric.
- Includes a per-transaction watchdog, so a hung slave cannot stall a core forever.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
WIDTHA, 16, address width
WIDTHD, 18, data width
TIMEOUT, 255, maximum BUSY cycles before abort; 0 disables the watchdog
WIDTHT, $clog2(TIMEOUT+1), watchdog counter width (derived; floor 1)

Ports:
clock  in  1  system clock
clock_sreset  in  1  reset, asynchronous, active-high
m_address  in  NUM_MASTERS*WIDTHA  packed master addresses, master i at [i*WIDTHA +: WIDTHA]
m_writedata  in  NUM_MASTERS*WIDTHD  packed master write data
m_read  in  NUM_MASTERS  per-master read request
m_write  in  NUM_MASTERS  per-master write request
m_readdata  out  WIDTHD  read data, broadcast to all masters
m_waitrequest  out  NUM_MASTERS  per-master wait; low only in that master's completion cycle
s_address  out  WIDTHA  slave address (registered)
s_writedata  out  WIDTHD  slave write data (registered)
s_read  out  1  slave read strobe (registered)
s_write  out  1  slave write strobe (registered)
s_readdata  in  WIDTHD  slave read data
s_waitrequest  in  1  slave wait
timeout  out  1  one-cycle pulse when the watchdog aborts a transaction
grant  out  NUM_MASTERS  one-hot owner of the slave port; all zero in IDLE

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - s_read=0, s_write=0, s_address=0, s_writedata=0.
  - grant=0, timeout=0.
  - last=NUM_MASTERS-1, so master 0 has first priority.
  - Watchdog count=0.
  - A reset mid-transaction drops s_read/s_write at once; the in-flight master never sees completion.
- States: IDLE, BUSY.
- Request: req[i] = m_read[i] | m_write[i].
- IDLE, when any req is set:
  - Pick the winner g by priority starting at last+1 and wrapping modulo NUM_MASTERS.
  - On the next edge: register s_address/s_writedata/s_read/s_write from master g, grant=onehot(g), count=0, state=BUSY.
  - If no req, stay IDLE with outputs at their reset values.
- BUSY, completion cycle (s_waitrequest=0):
  - m_waitrequest[g]=0 combinationally in that cycle; m_readdata=s_readdata.
  - Next edge: s_read=0, s_write=0, grant=0, last=g, state=IDLE.
- BUSY, slave waiting: count increments each cycle while s_waitrequest=1.
- Watchdog abort, when TIMEOUT!=0 and count==TIMEOUT-1 while s_waitrequest=1:
  - m_waitrequest[g]=0 and m_readdata=all ones in that cycle.
  - timeout pulses high for the same cycle.
  - Next edge behaves exactly as a normal completion.
- Non-granted masters: m_waitrequest=1 at all times. m_waitrequest is all ones in IDLE.
- Latency:
  - Request at cycle 0 with slave ready puts s_read/s_write high in cycle 1; completion at the earliest in cycle 1.
  - Re-arbitration happens in the IDLE cycle after completion, so back-to-back grants are spaced by one idle cycle.
- Fairness:
  - A master that just completed has lowest priority next.
  - With all masters requesting, grants rotate 0,1,...,N-1,0.
- Simultaneous m_read and m_write from one master: forwarded unchanged; this is illegal and is flagged by a bench assertion.
- Masters must hold request, address and data stable until completion. The arbiter latches them at grant and ignores later changes.
- Request deasserted by the granted master mid-transaction: ignored; the transaction still runs to completion.

Decomposition:
- Package micro_bus_pkg holds:
  - the state enum typedef (IDLE, BUSY);
  - the ALL_ONES read-data constant used on abort.
- Sub-module rr_priority: combinational round-robin select.
  - Inputs: req[N], last index.
  - Outputs: onehot grant, binary index, any-request flag.
  - Implemented as a rotate, then find-first-set, then un-rotate.
- The top level holds the FSM, the output registers and the watchdog.

Test Plan:
- Reset release; m_read[0]=1 at address 0x0024, slave ready -> s_read=1 with s_address=0x0024 in cycle 1; m_waitrequest=2'b10 in cycle 1; s_read=0 in cycle 2.
- m_read=2'b11 continuously, slave always ready -> grants alternate 0,1,0,1; each completes with an idle cycle between; no master wins twice in a row.
- Master 1 writes 0x155AA to 0x01E0, s_waitrequest high for 3 cycles -> s_write held 4 cycles with stable address/data; m_waitrequest[1] low only in the 4th.
- TIMEOUT=4, slave waitrequest stuck high on a read -> in the 4th BUSY cycle timeout=1, m_waitrequest[g]=0 and m_readdata=0x3FFFF; IDLE on the next cycle.
- Assert clock_sreset while BUSY -> s_read/s_write/grant go 0 asynchronously; after release, master 0 wins first when both request.
- Master 0 changes m_address while BUSY -> s_address unchanged until completion.
